// File: rtl/block_dispatcher_pkg.sv
// gpu_pkg: shared types and defaults for the minigpu kernel dispatcher.
//   disp_state_t - global kernel FSM (IDLE / RUN / DONE)
//   slot_state_t - per-core slot FSM (FREE / RST / BUSY)
//   DEFAULT_THREADS_PER_BLOCK - threads per full block, equal to threads per core
//   min_width() - index width helper that never returns 0
package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } disp_state_t;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      RST  = 2'd1,
      BUSY = 2'd2
   } slot_state_t;

   localparam int DEFAULT_THREADS_PER_BLOCK = 4;

   function automatic int min_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/block_dispatcher_picker.sv
// free_core_picker: combinational lowest-index priority encoder over the
// FREE-slot vector.
//   free_mask - bit i set when core i is FREE
//   valid     - at least one core is FREE
//   idx       - index of the lowest FREE core (0 when none)
module free_core_picker #(
   parameter int NUM_CORES = 4,
   parameter int IDX_W     = gpu_pkg::min_width(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] free_mask,
   output logic                 valid,
   output logic [IDX_W-1:0]     idx
);

   // Scanning downward lets the lowest set bit be the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (free_mask[i]) begin
            valid = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel launch of thread_count threads into
// blocks of THREADS_PER_BLOCK and hands them to NUM_CORES compute units,
// reusing a core as soon as it reports completion.
//   clk, reset        - clock, synchronous active-high reset
//   kernel_start      - launch pulse, only honoured in IDLE
//   thread_count      - total threads, captured with an accepted start
//   core_done         - per-core level, block finished
//   core_reset        - per-core one-cycle reset pulse (slot in RST)
//   core_enable       - per-core run enable (slot in BUSY)
//   core_block_id     - packed per-core block index
//   core_thread_count - packed per-core active thread count
//   kernel_busy       - high from accepted start until completion
//   kernel_done       - one-cycle completion pulse
//   kernel_cycles     - RUN cycle counter, only with BLOCK_DISPATCHER_PERF_EN
// Handshake: a core owns a block from its RST cycle until core_done is
// sampled high while BUSY; core_done is ignored in FREE and RST.
// All outputs come straight from flops.
module block_dispatcher #(
   parameter int  NUM_CORES         = 4,
   parameter int  THREADS_PER_BLOCK = gpu_pkg::DEFAULT_THREADS_PER_BLOCK,
   parameter int  MAX_THREADS       = 64,
   localparam int TC_W       = $clog2(MAX_THREADS + 1),
   localparam int MAX_BLOCKS = (MAX_THREADS + THREADS_PER_BLOCK - 1) / THREADS_PER_BLOCK,
   localparam int BID_W      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1,
   localparam int BT_W       = $clog2(THREADS_PER_BLOCK + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       kernel_start,
   input  logic [TC_W-1:0]            thread_count,
   input  logic [NUM_CORES-1:0]       core_done,
   output logic [NUM_CORES-1:0]       core_reset,
   output logic [NUM_CORES-1:0]       core_enable,
   output logic [NUM_CORES*BID_W-1:0] core_block_id,
   output logic [NUM_CORES*BT_W-1:0]  core_thread_count,
   output logic                       kernel_busy,
   output logic                       kernel_done
`ifdef BLOCK_DISPATCHER_PERF_EN
   ,
   output logic [31:0]                kernel_cycles
`endif
);

   import gpu_pkg::*;

   localparam int IDX_W = min_width(NUM_CORES);

   disp_state_t          state_q, state_d;
   slot_state_t          slot_q [NUM_CORES];
   slot_state_t          slot_d [NUM_CORES];
   logic [TC_W-1:0]      tc_q, tc_d;
   logic [TC_W-1:0]      total_q, total_d;
   logic [TC_W-1:0]      next_q, next_d;
   logic [TC_W-1:0]      done_cnt_q, done_cnt_d;
   logic [BID_W-1:0]     bid_q [NUM_CORES];
   logic [BID_W-1:0]     bid_d [NUM_CORES];
   logic [BT_W-1:0]      bt_q [NUM_CORES];
   logic [BT_W-1:0]      bt_d [NUM_CORES];
   logic [NUM_CORES-1:0] core_reset_q, core_reset_d;
   logic [NUM_CORES-1:0] core_enable_q, core_enable_d;
   logic                 kernel_busy_q, kernel_busy_d;
   logic                 kernel_done_q, kernel_done_d;

   logic [NUM_CORES-1:0] free_mask;
   logic [NUM_CORES-1:0] assign_vec;
   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic                 assign_en;
   logic [TC_W-1:0]      n_done;
   logic [TC_W:0]        tc_round;
   logic [TC_W-1:0]      remaining;
   logic [BT_W-1:0]      blk_threads;

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) free_mask[i] = (slot_q[i] == FREE);
   end

   free_core_picker #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_picker (
      .free_mask (free_mask),
      .valid     (pick_valid),
      .idx       (pick_idx)
   );

   // One block per cycle at most, and never past the last block id.
   assign assign_en = (state_q == RUN) && pick_valid && (next_q < total_q);

   always_comb begin
      assign_vec = '0;
      if (assign_en) assign_vec[pick_idx] = 1'b1;
   end

   // Ceiling division is done one bit wider so MAX_THREADS cannot overflow.
   assign tc_round    = {1'b0, thread_count} + (TC_W + 1)'(THREADS_PER_BLOCK - 1);
   assign remaining   = tc_q - TC_W'(next_q * TC_W'(THREADS_PER_BLOCK));
   assign blk_threads = (remaining > TC_W'(THREADS_PER_BLOCK)) ? BT_W'(THREADS_PER_BLOCK)
                                                              : BT_W'(remaining);

   // Completions counted this edge; several cores may finish together.
   always_comb begin
      n_done = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if ((slot_q[i] == BUSY) && core_done[i]) n_done = n_done + TC_W'(1);
      end
   end

   // Global next state. A zero-thread launch spends one cycle in RUN with
   // total_blocks == blocks_done == 0, so it reports busy for one cycle and
   // completes without assigning any core.
   always_comb begin
      state_d    = state_q;
      tc_d       = tc_q;
      total_d    = total_q;
      next_d     = next_q;
      done_cnt_d = done_cnt_q + n_done;
      if (assign_en) next_d = next_q + TC_W'(1);
      case (state_q)
         IDLE: begin
            if (kernel_start) begin
               state_d    = RUN;
               tc_d       = thread_count;
               total_d    = TC_W'(tc_round / (TC_W + 1)'(THREADS_PER_BLOCK));
               next_d     = '0;
               done_cnt_d = '0;
            end
         end
         RUN:     if (done_cnt_q == total_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slot next state.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         slot_d[i] = slot_q[i];
         case (slot_q[i])
            FREE:    if (assign_vec[i]) slot_d[i] = RST;
            RST:     slot_d[i] = BUSY;
            BUSY:    if (core_done[i]) slot_d[i] = FREE;
            default: slot_d[i] = FREE;
         endcase
      end
   end

   // Outputs are decoded from next state so that they leave the flops in
   // step with the state they describe.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         core_reset_d[i]  = (slot_d[i] == RST);
         core_enable_d[i] = (slot_d[i] == BUSY);
         bid_d[i]         = bid_q[i];
         bt_d[i]          = bt_q[i];
         if (assign_vec[i]) begin
            bid_d[i] = BID_W'(next_q);
            bt_d[i]  = blk_threads;
         end
      end
      kernel_busy_d = (state_d == RUN);
      kernel_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         tc_q          <= '0;
         total_q       <= '0;
         next_q        <= '0;
         done_cnt_q    <= '0;
         core_reset_q  <= '0;
         core_enable_q <= '0;
         kernel_busy_q <= 1'b0;
         kernel_done_q <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) begin
            slot_q[i] <= FREE;
            bid_q[i]  <= '0;
            bt_q[i]   <= '0;
         end
      end else begin
         state_q       <= state_d;
         tc_q          <= tc_d;
         total_q       <= total_d;
         next_q        <= next_d;
         done_cnt_q    <= done_cnt_d;
         core_reset_q  <= core_reset_d;
         core_enable_q <= core_enable_d;
         kernel_busy_q <= kernel_busy_d;
         kernel_done_q <= kernel_done_d;
         for (int i = 0; i < NUM_CORES; i++) begin
            slot_q[i] <= slot_d[i];
            bid_q[i]  <= bid_d[i];
            bt_q[i]   <= bt_d[i];
         end
      end
   end

   assign core_reset  = core_reset_q;
   assign core_enable = core_enable_q;
   assign kernel_busy = kernel_busy_q;
   assign kernel_done = kernel_done_q;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
      assign core_block_id[g*BID_W +: BID_W]    = bid_q[g];
      assign core_thread_count[g*BT_W +: BT_W]  = bt_q[g];
   end

`ifdef BLOCK_DISPATCHER_PERF_EN
   // Cleared on an accepted start, counts RUN cycles, holds otherwise.
   logic [31:0] cycles_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= '0;
      end else if ((state_q == IDLE) && kernel_start) begin
         cycles_q <= '0;
      end else if (state_q == RUN) begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   assign kernel_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher with default parameters.
module tb_block_dispatcher;

   localparam int NC    = 4;
   localparam int TPB   = 4;
   localparam int MAXT  = 64;
   localparam int TC_W  = $clog2(MAXT + 1);
   localparam int MAXB  = (MAXT + TPB - 1) / TPB;
   localparam int BID_W = (MAXB > 1) ? $clog2(MAXB) : 1;
   localparam int BT_W  = $clog2(TPB + 1);
   localparam int EW    = BID_W + BT_W;

   // ---------------- clock / reset / DUT ----------------
   logic                   clk = 1'b0;
   logic                   reset;
   logic                   kernel_start;
   logic [TC_W-1:0]        thread_count;
   logic [NC-1:0]          core_done;
   logic [NC-1:0]          core_reset;
   logic [NC-1:0]          core_enable;
   logic [NC*BID_W-1:0]    core_block_id;
   logic [NC*BT_W-1:0]     core_thread_count;
   logic                   kernel_busy;
   logic                   kernel_done;
`ifdef BLOCK_DISPATCHER_PERF_EN
   logic [31:0]            kernel_cycles;
`endif

   always #5 clk = ~clk;

   block_dispatcher #(
      .NUM_CORES         (NC),
      .THREADS_PER_BLOCK (TPB),
      .MAX_THREADS       (MAXT)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .kernel_start      (kernel_start),
      .thread_count      (thread_count),
      .core_done         (core_done),
      .core_reset        (core_reset),
      .core_enable       (core_enable),
      .core_block_id     (core_block_id),
      .core_thread_count (core_thread_count),
      .kernel_busy       (kernel_busy),
      .kernel_done       (kernel_done)
`ifdef BLOCK_DISPATCHER_PERF_EN
      ,
      .kernel_cycles     (kernel_cycles)
`endif
   );

   // ---------------- scoreboard state ----------------
   int               vectors = 0;
   int               miscompares = 0;
   logic [EW-1:0]    exp_q[$];
   logic [NC-1:0]    reset_seen;
   logic [NC-1:0]    enable_seen;
   logic [MAXB-1:0]  id_seen;
   int               core_of_block [MAXB];
   int               assign_cnt;
   int               done_pulses;

   // core responder model
   bit               auto_done = 1'b0;
   int               lat [NC];
   int               busy_cnt [NC];

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_stats();
      reset_seen  = '0;
      enable_seen = '0;
      id_seen     = '0;
      assign_cnt  = 0;
      done_pulses = 0;
      for (int b = 0; b < MAXB; b++) core_of_block[b] = -1;
   endtask

   // Pushes the expected block sequence, then pulses kernel_start; returns
   // at the falling edge just after the start was sampled.
   task automatic start_kernel(input int tc);
      int nb;
      int cnt;
      nb = (tc + TPB - 1) / TPB;
      for (int b = 0; b < nb; b++) begin
         cnt = tc - b * TPB;
         if (cnt > TPB) cnt = TPB;
         exp_q.push_back({BID_W'(b), BT_W'(cnt)});
      end
      clear_stats();
      thread_count = TC_W'(tc);
      kernel_start = 1'b1;
      tick();
      kernel_start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         tick();
         if (kernel_done) begin
            seen = 1'b1;
            break;
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_timeout: kernel_done not seen in %0d cycles, required a pulse", name, max_cycles);
      end
   endtask

   task automatic wait_enable(input logic [NC-1:0] mask, input int max_cycles, input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         tick();
         if (core_enable == mask) begin
            seen = 1'b1;
            break;
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_timeout: core_enable=%b, required %b", name, core_enable, mask);
      end
   endtask

   // ---------------- monitor: assignments vs expected queue ----------------
   always @(negedge clk) begin
      logic [EW-1:0]    got;
      logic [EW-1:0]    exp;
      logic [BID_W-1:0] bid;
      if (!reset) begin
         if (kernel_done) done_pulses++;
         if (core_reset != '0) begin
            vectors++;
            if ($countones(core_reset) > 1) begin
               miscompares++;
               $display("FAIL one_assign_per_cycle: core_reset=%b, required one-hot", core_reset);
            end
         end
         for (int i = 0; i < NC; i++) begin
            if (core_enable[i]) enable_seen[i] = 1'b1;
            if (core_reset[i]) begin
               reset_seen[i] = 1'b1;
               assign_cnt++;
               bid = core_block_id[i*BID_W +: BID_W];
               got = {bid, core_thread_count[i*BT_W +: BT_W]};
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL assign_extra: core %0d got id/cnt %0h, required no assignment", i, got);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     miscompares++;
                     $display("FAIL assign_core%0d: got id/cnt %0h, required %0h", i, got, exp);
                  end
               end
               vectors++;
               if (id_seen[bid]) begin
                  miscompares++;
                  $display("FAIL dup_block_id: id %0d issued again to core %0d, required once", bid, i);
               end
               id_seen[bid]       = 1'b1;
               core_of_block[bid] = i;
            end
         end
      end
   end

   // ---------------- core responder ----------------
   // A core raises done lat cycles after enable and leaves it high (stale)
   // until it is enabled for a new block.
   always @(negedge clk) begin
      if (auto_done) begin
         for (int i = 0; i < NC; i++) begin
            if (core_enable[i]) begin
               if (busy_cnt[i] == 0) core_done[i] = 1'b0;
               busy_cnt[i]++;
               if (busy_cnt[i] >= lat[i]) core_done[i] = 1'b1;
            end else begin
               busy_cnt[i] = 0;
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      reset        = 1'b1;
      kernel_start = 1'b0;
      thread_count = '0;
      core_done    = '0;
      for (int i = 0; i < NC; i++) begin
         lat[i]      = 1;
         busy_cnt[i] = 0;
      end
      clear_stats();
      repeat (3) tick();
      vectors++;
      if ({core_reset, core_enable} !== '0) begin
         miscompares++;
         $display("FAIL reset_core_ctl: got %b, required 0", {core_reset, core_enable});
      end
      vectors++;
      if ({core_block_id, core_thread_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_core_data: got %0h, required 0", {core_block_id, core_thread_count});
      end
      vectors++;
      if ({kernel_busy, kernel_done} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_kernel: got %b, required 00", {kernel_busy, kernel_done});
      end
`ifdef BLOCK_DISPATCHER_PERF_EN
      vectors++;
      if (kernel_cycles !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_cycles: got %0d, required 0", kernel_cycles);
      end
`endif
      reset = 1'b0;
      repeat (2) tick();
      vectors++;
      if (kernel_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_no_start: kernel_busy=%b, required 0", kernel_busy);
      end
   endtask

   task automatic test_full_blocks();
      logic [NC*BID_W-1:0] exp_ids;
      logic [NC*BT_W-1:0]  exp_cnts;
      auto_done = 1'b0;
      core_done = '0;
      start_kernel(16);
      vectors++;
      if ({kernel_busy, core_reset} !== {1'b1, 4'b0000}) begin
         miscompares++;
         $display("FAIL full_start: busy/core_reset=%b, required 1_0000", {kernel_busy, core_reset});
      end
      tick();
      vectors++;
      if ({core_reset, core_enable} !== {4'b0001, 4'b0000}) begin
         miscompares++;
         $display("FAIL full_first_reset: reset/enable=%b, required 0001_0000", {core_reset, core_enable});
      end
      tick();
      vectors++;
      if ({core_reset, core_enable} !== {4'b0010, 4'b0001}) begin
         miscompares++;
         $display("FAIL full_first_enable: reset/enable=%b, required 0010_0001", {core_reset, core_enable});
      end
      wait_enable(4'b1111, 10, "full_all_enabled");
      for (int i = 0; i < NC; i++) begin
         exp_ids[i*BID_W +: BID_W] = BID_W'(i);
         exp_cnts[i*BT_W +: BT_W]  = BT_W'(TPB);
      end
      vectors++;
      if ({core_block_id, core_thread_count} !== {exp_ids, exp_cnts}) begin
         miscompares++;
         $display("FAIL full_ids: got %0h, required %0h", {core_block_id, core_thread_count}, {exp_ids, exp_cnts});
      end
      core_done = '1;
      tick();
      vectors++;
      if ({kernel_done, kernel_busy, core_enable} !== {1'b0, 1'b1, 4'b0000}) begin
         miscompares++;
         $display("FAIL full_done_sampled: done/busy/enable=%b, required 0_1_0000", {kernel_done, kernel_busy, core_enable});
      end
      tick();
      vectors++;
      if ({kernel_done, kernel_busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL full_done_pulse: done/busy=%b, required 10", {kernel_done, kernel_busy});
      end
      tick();
      core_done = '0;
      vectors++;
      if ({kernel_done, done_pulses} !== {1'b0, 32'd1}) begin
         miscompares++;
         $display("FAIL full_done_once: kernel_done=%b pulses=%0d, required 0 and 1", kernel_done, done_pulses);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL full_queue: %0d blocks never assigned, required 0", exp_q.size());
      end
   endtask

   task automatic test_zero();
      auto_done = 1'b0;
      core_done = '0;
      start_kernel(0);
      vectors++;
      if ({kernel_busy, kernel_done} !== 2'b10) begin
         miscompares++;
         $display("FAIL zero_busy: busy/done=%b, required 10", {kernel_busy, kernel_done});
      end
      tick();
      vectors++;
      if ({kernel_busy, kernel_done} !== 2'b01) begin
         miscompares++;
         $display("FAIL zero_done: busy/done=%b, required 01", {kernel_busy, kernel_done});
      end
      tick();
      vectors++;
      if ({kernel_done, reset_seen, enable_seen} !== '0) begin
         miscompares++;
         $display("FAIL zero_no_cores: done/reset_seen/enable_seen=%b, required 0", {kernel_done, reset_seen, enable_seen});
      end
   endtask

   task automatic test_partial();
      for (int i = 0; i < NC; i++) lat[i] = 3;
      auto_done = 1'b1;
      start_kernel(10);
      wait_done(200, "partial");
      vectors++;
      if ({reset_seen, enable_seen} !== {4'b0111, 4'b0111}) begin
         miscompares++;
         $display("FAIL partial_cores: reset_seen/enable_seen=%b, required 0111_0111", {reset_seen, enable_seen});
      end
      vectors++;
      if (assign_cnt != 3 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL partial_blocks: assigned=%0d left=%0d, required 3 and 0", assign_cnt, exp_q.size());
      end
      tick();
   endtask

   task automatic test_reuse();
      logic [MAXB-1:0] exp_seen;
      exp_seen = MAXB'(16'h03ff);
      lat[0] = 10;
      lat[1] = 2;
      lat[2] = 10;
      lat[3] = 10;
      auto_done = 1'b1;
      start_kernel(37);
      repeat (3) tick();
      // a start while running must be ignored
      thread_count = TC_W'(4);
      kernel_start = 1'b1;
      tick();
      kernel_start = 1'b0;
      wait_done(400, "reuse");
      vectors++;
      if (core_of_block[4] != 1) begin
         miscompares++;
         $display("FAIL reuse_block4_core: got core %0d, required 1", core_of_block[4]);
      end
      vectors++;
      if (id_seen !== exp_seen || assign_cnt != 10) begin
         miscompares++;
         $display("FAIL reuse_ids: seen=%b count=%0d, required %b and 10", id_seen, assign_cnt, exp_seen);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL reuse_queue: %0d blocks never assigned, required 0", exp_q.size());
      end
      tick();
      vectors++;
      if ({kernel_done, kernel_busy, done_pulses} !== {2'b00, 32'd1}) begin
         miscompares++;
         $display("FAIL reuse_end: done/busy=%b pulses=%0d, required 00 and 1", {kernel_done, kernel_busy}, done_pulses);
      end
   endtask

   task automatic test_abort();
      auto_done = 1'b0;
      core_done = '0;
      start_kernel(16);
      wait_enable(4'b0011, 10, "abort_two_busy");
      reset = 1'b1;
      tick();
      vectors++;
      if ({core_reset, core_enable, kernel_busy, kernel_done} !== '0) begin
         miscompares++;
         $display("FAIL abort_ctl: got %b, required 0", {core_reset, core_enable, kernel_busy, kernel_done});
      end
      vectors++;
      if ({core_block_id, core_thread_count} !== '0) begin
         miscompares++;
         $display("FAIL abort_data: got %0h, required 0", {core_block_id, core_thread_count});
      end
      exp_q.delete();
      clear_stats();
      reset = 1'b0;
      repeat (5) tick();
      vectors++;
      if ({done_pulses, reset_seen, enable_seen} !== '0) begin
         miscompares++;
         $display("FAIL abort_quiet: pulses=%0d reset_seen=%b enable_seen=%b, required 0", done_pulses, reset_seen, enable_seen);
      end
      for (int i = 0; i < NC; i++) lat[i] = 2;
      auto_done = 1'b1;
      start_kernel(4);
      wait_done(50, "abort_restart");
      vectors++;
      if (assign_cnt != 1 || exp_q.size() != 0 || reset_seen !== 4'b0001) begin
         miscompares++;
         $display("FAIL abort_restart: assigned=%0d left=%0d reset_seen=%b, required 1, 0, 0001", assign_cnt, exp_q.size(), reset_seen);
      end
      tick();
   endtask

`ifdef BLOCK_DISPATCHER_PERF_EN
   task automatic test_perf();
      auto_done = 1'b0;
      core_done = '0;
      tick();
      start_kernel(4);
      vectors++;
      if (kernel_cycles !== 32'd0) begin
         miscompares++;
         $display("FAIL perf_clear: got %0d, required 0", kernel_cycles);
      end
      wait_enable(4'b0001, 10, "perf_enable");
      repeat (19) tick();
      core_done[0] = 1'b1;
      wait_done(10, "perf");
      core_done = '0;
      vectors++;
      if (kernel_cycles !== 32'd23) begin
         miscompares++;
         $display("FAIL perf_count: got %0d, required 23", kernel_cycles);
      end
      repeat (3) tick();
      vectors++;
      if (kernel_cycles !== 32'd23) begin
         miscompares++;
         $display("FAIL perf_hold: got %0d, required 23", kernel_cycles);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_full_blocks();
      test_zero();
      test_partial();
      test_reuse();
      test_abort();
`ifdef BLOCK_DISPATCHER_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
